sobel_edge: RTL and testbench

- Streaming Sobel edge detector between the UART byte receiver and the VGA frame RAM writer.
- Consumes one 8-bit grey pixel per pi_flag pulse, raster order, for an image of COL_MAX x ROW_MAX (default 180x180 = 32400 bytes).
- Emits one binarised edge pixel per interior position: (COL_MAX-2) x (ROW_MAX-2) outputs per frame.

---
 rtl/sobel_edge_pkg.sv | 29 ++
 rtl/sobel_edge_if.sv | 15 +
 rtl/sobel_line_buf.sv | 22 ++
 rtl/sobel_edge.sv | 137 +++++++++++++
 tb/tb_sobel_edge.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/sobel_edge_pkg.sv
// Shared pixel-stream definitions for the UART -> Sobel -> VGA frame path.
// Also holds the gradient helpers used by the edge detector.
package edge_pkg;
  localparam int COL_MAX   = 180;
  localparam int ROW_MAX   = 180;
  localparam int PIX_W     = 8;
  localparam int FRAME_PIX = COL_MAX * ROW_MAX;

  localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

  typedef logic        [PIX_W-1:0] pix_t;
  typedef logic signed [10:0]      grad_t;
  typedef logic        [10:0]      mag_t;

  // (a + 2b + c) - (d + 2e + f); the worst case of +/-1020 fits in 11 signed bits
  function automatic grad_t sobel_diff(input pix_t a, input pix_t b, input pix_t c,
                                       input pix_t d, input pix_t e, input pix_t f);
    grad_t pos;
    grad_t neg;
    pos = $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
    neg = $signed({3'b000, d}) + $signed({2'b00, e, 1'b0}) + $signed({3'b000, f});
    return pos - neg;
  endfunction

  function automatic mag_t abs_grad(input grad_t g);
    return g[10] ? mag_t'(-g) : mag_t'(g);
  endfunction
endpackage

// File: rtl/sobel_edge_if.sv
// Pixel-in / edge-out stream bundle of the Sobel stage.
interface sobel_edge_if;
  import edge_pkg::*;

  pix_t pi_data;
  logic pi_flag;
  pix_t po_data;
  logic po_flag;
  logic po_frame_done;

  modport master (output pi_data, output pi_flag,
                  input  po_data, input  po_flag, input po_frame_done);
  modport slave  (input  pi_data, input  pi_flag,
                  output po_data, output po_flag, output po_frame_done);
endinterface

// File: rtl/sobel_line_buf.sv
// One image line of storage: asynchronous read, synchronous write.
module sobel_line_buf #(
  parameter int DEPTH = 180,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // Same-cycle read returns the pre-write contents
  assign dout = mem[addr];
endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a 3x3 window,
// registered gradients and a threshold stage (3 cycles pixel-in to edge-out).
module sobel_edge #(
  parameter int         COL_MAX   = edge_pkg::COL_MAX,
  parameter int         ROW_MAX   = edge_pkg::ROW_MAX,
  parameter logic [10:0] THRESHOLD = 11'd100
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  sobel_edge_if.slave  io
);
  import edge_pkg::*;

  localparam int COL_W = $clog2(COL_MAX);
  localparam int ROW_W = $clog2(ROW_MAX);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_MAX - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_MAX - 1);

  logic [COL_W-1:0] col_cnt_reg;
  logic [ROW_W-1:0] row_cnt_reg;
  logic             col_last;
  logic             row_last;

  assign col_last = (col_cnt_reg == COL_LAST);
  assign row_last = (row_cnt_reg == ROW_LAST);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
    end else if (io.pi_flag) begin
      if (col_last) begin
        col_cnt_reg <= '0;
        row_cnt_reg <= row_last ? '0 : row_cnt_reg + 1'b1;
      end else begin
        col_cnt_reg <= col_cnt_reg + 1'b1;
      end
    end
  end

  // lb[0] holds row r-1, lb[1] holds row r-2; lb[1] is refilled from lb[0]
  pix_t lb_din  [2];
  pix_t lb_dout [2];

  assign lb_din[0] = io.pi_data;
  assign lb_din[1] = lb_dout[0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lb
      sobel_line_buf #(.DEPTH(COL_MAX), .WIDTH(PIX_W)) u_lb (
        .clk  (sys_clk),
        .we   (io.pi_flag),
        .addr (col_cnt_reg),
        .din  (lb_din[gi]),
        .dout (lb_dout[gi])
      );
    end
  endgenerate

  // win_reg[row][col]: row 0 = top (r-2), col 2 = newest column
  pix_t win_reg [3][3];
  pix_t new_col [3];
  logic v1_reg;
  logic last1_reg;

  assign new_col[0] = lb_dout[1];
  assign new_col[1] = lb_dout[0];
  assign new_col[2] = io.pi_data;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_reg[r][c] <= '0;
        end
      end
      v1_reg    <= 1'b0;
      last1_reg <= 1'b0;
    end else begin
      v1_reg    <= io.pi_flag && (col_cnt_reg >= COL_W'(2)) && (row_cnt_reg >= ROW_W'(2));
      last1_reg <= io.pi_flag && col_last && row_last;
      if (io.pi_flag) begin
        for (int r = 0; r < 3; r++) begin
          win_reg[r][0] <= win_reg[r][1];
          win_reg[r][1] <= win_reg[r][2];
          win_reg[r][2] <= new_col[r];
        end
      end
    end
  end

  grad_t gx_reg;
  grad_t gy_reg;
  logic  v2_reg;
  logic  last2_reg;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      gx_reg    <= '0;
      gy_reg    <= '0;
      v2_reg    <= 1'b0;
      last2_reg <= 1'b0;
    end else begin
      gx_reg    <= sobel_diff(win_reg[0][2], win_reg[1][2], win_reg[2][2],
                              win_reg[0][0], win_reg[1][0], win_reg[2][0]);
      gy_reg    <= sobel_diff(win_reg[2][0], win_reg[2][1], win_reg[2][2],
                              win_reg[0][0], win_reg[0][1], win_reg[0][2]);
      v2_reg    <= v1_reg;
      last2_reg <= v1_reg && last1_reg;
    end
  end

  mag_t mag;
  pix_t po_data_reg;
  logic po_flag_reg;
  logic po_frame_done_reg;

  assign mag = abs_grad(gx_reg) + abs_grad(gy_reg);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      po_data_reg       <= EDGE_OFF;
      po_flag_reg       <= 1'b0;
      po_frame_done_reg <= 1'b0;
    end else begin
      po_flag_reg       <= v2_reg;
      po_frame_done_reg <= last2_reg;
      if (v2_reg) begin
        po_data_reg <= (mag >= THRESHOLD) ? EDGE_ON : EDGE_OFF;
      end
    end
  end

  assign io.po_data       = po_data_reg;
  assign io.po_flag       = po_flag_reg;
  assign io.po_frame_done = po_frame_done_reg;
endmodule

// File: tb/tb_sobel_edge.sv
// Randomised frame bench for sobel_edge on a reduced image, with a 2-D
// image reference model and a cycle-stamped output scoreboard.
module tb_sobel_edge;
  import edge_pkg::*;

  localparam int          C   = 16;
  localparam int          R   = 12;
  localparam int          NOUT = (C - 2) * (R - 2);
  localparam logic [10:0] THR = 11'd100;

  typedef struct {
    logic [7:0] data;
    logic       done;
    int         cyc;
    int         cx;
    int         cy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_edge_if bus ();

  sobel_edge #(.COL_MAX(C), .ROW_MAX(R), .THRESHOLD(THR)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .io        (bus.slave)
  );

  exp_t exp_q [$];
  int   img [R][C];
  int   tb_col = 0;
  int   tb_row = 0;
  int   tests = 0;
  int   fails = 0;
  int   n_flag = 0;
  int   n_done = 0;

  task automatic check(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Reference: Sobel straight from the 2-D image around centre (cx,cy)
  function automatic logic [7:0] ref_edge(input int cx, input int cy);
    int gx, gy, mag;
    gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
       - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
    gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
       - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag >= int'(THR)) ? 8'hFF : 8'h00;
  endfunction

  function automatic int pat(input int p, input int x, input int y);
    case (p)
      0:       return 'h80;
      1:       return (x < C/2) ? 0 : 255;
      2:       return (y < R/2) ? 0 : 255;
      3:       return (x == 5 && y == 5) ? 255 : 0;
      4:       return (x < C/2) ? 0 : 25;   // |Gx| = 100, exactly at threshold
      5:       return (x < C/2) ? 0 : 24;   // |Gx| = 96, just below
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Drive one pixel; gap = edges from this pi_flag to the next (>= 2 here)
  task automatic send(input int d, input int gap);
    exp_t e;
    @(posedge clk); #1;
    bus.pi_data = d[7:0];
    bus.pi_flag = 1'b1;
    img[tb_row][tb_col] = d;
    if (tb_col >= 2 && tb_row >= 2) begin
      e.cx   = tb_col - 1;
      e.cy   = tb_row - 1;
      e.data = ref_edge(e.cx, e.cy);
      e.done = (tb_col == C-1) && (tb_row == R-1);
      e.cyc  = cyc + 3;
      exp_q.push_back(e);
    end
    if (tb_col == C-1) begin
      tb_col = 0;
      tb_row = (tb_row == R-1) ? 0 : tb_row + 1;
    end else begin
      tb_col++;
    end
    @(posedge clk); #1;
    bus.pi_flag = 1'b0;
    repeat (gap - 2) @(posedge clk);
  endtask

  task automatic send_frame(input int p, input bit tight);
    for (int y = 0; y < R; y++)
      for (int x = 0; x < C; x++)
        send(pat(p, x, y), tight ? 4 : int'($urandom_range(4, 9)));
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic run_frame(input string name, input int p, input bit tight);
    int f0, d0;
    f0 = n_flag;
    d0 = n_done;
    send_frame(p, tight);
    drain(name);
    check({name, "_flags"}, n_flag - f0, NOUT);
    check({name, "_done"}, n_done - d0, 1);
    $display("[TB] frame %s: %0d outputs, %0d frame_done", name, n_flag - f0, n_done - d0);
  endtask

  // Monitor: every po_flag must match the head of the scoreboard, cycle-exact
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.po_frame_done && !bus.po_flag) begin
      tests++;
      fails++;
      $display("FAIL done_without_flag: po_frame_done=1 with po_flag=0 at cycle %0d", cyc);
    end
    if (bus.po_flag) begin
      n_flag++;
      if (bus.po_frame_done) n_done++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_po_flag: got po_flag at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.po_data !== e.data || bus.po_frame_done !== e.done || cyc != e.cyc) begin
          fails++;
          $display("FAIL pixel(%0d,%0d): got data=%02h done=%0b cyc=%0d, expected data=%02h done=%0b cyc=%0d",
                   e.cx, e.cy, bus.po_data, bus.po_frame_done, cyc, e.data, e.done, e.cyc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int f0;
    bus.pi_data = 8'h00;
    bus.pi_flag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_po_flag", int'(bus.po_flag), 0);
    check("rst_po_data", int'(bus.po_data), 0);
    check("rst_po_done", int'(bus.po_frame_done), 0);
    rst_n = 1'b1;

    run_frame("flat", 0, 1'b1);
    run_frame("vstep", 1, 1'b0);
    run_frame("hstep", 2, 1'b0);
    run_frame("dot", 3, 1'b0);
    run_frame("thr_eq", 4, 1'b0);
    run_frame("thr_below", 5, 1'b0);
    run_frame("random", 6, 1'b0);

    // Reset one cycle after a qualifying pixel: its output must never appear
    for (int i = 0; i < 99; i++) send(pat(6, i % C, i / C), 4);
    send(pat(6, 99 % C, 99 / C), 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    tb_col = 0;
    tb_row = 0;
    f0 = n_flag;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_flag", n_flag - f0, 0);
    check("midrst_po_flag", int'(bus.po_flag), 0);
    $display("[TB] mid-frame reset: %0d outputs after reset", n_flag - f0);
    run_frame("after_rst", 0, 1'b1);

    // Two frames back-to-back at the minimum spacing
    f0 = n_done;
    begin
      int fl;
      fl = n_flag;
      send_frame(6, 1'b1);
      send_frame(6, 1'b1);
      drain("b2b");
      check("b2b_flags", n_flag - fl, 2 * NOUT);
      check("b2b_done", n_done - f0, 2);
      $display("[TB] back-to-back: %0d outputs, %0d frame_done", n_flag - fl, n_done - f0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
